// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants, FSM encoding and clog2 helper for the FIR MAC filter
package fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_COEF_W = 16;
    localparam int FIR_TAPS   = 16;
    localparam int FIR_SHIFT  = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } fir_state_t;

    // Smallest r with 2**r >= value; returns at least 1 so index ports never collapse to zero width.
    function automatic int fir_clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - signed multiplier with wide clearable/enabled accumulator
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the accumulator (takes priority over en)
//   en       : add a*b into the accumulator
//   a, b     : signed multiplicands
//   acc      : signed running sum, ACC_W bits
module fir_mac #(
    parameter int A_W   = 16,
    parameter int B_W   = 16,
    parameter int ACC_W = 36
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [A_W+B_W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            // size cast of a signed operand sign-extends the product
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/fir_mac_filter.sv
// rtl/fir_mac_filter.sv - runtime-programmable direct-form FIR using one time-shared MAC
//
// Ports:
//   Clk, Rst              : clock, synchronous active-high reset
//   Xin, Xin_valid        : signed input sample and its valid strobe
//   Xin_ready             : high while idle; a sample is taken when valid and ready
//   Yout, Yout_valid      : rounded, width-reduced result and its one-cycle pulse
//   Coef_we, Coef_addr,
//   Coef_data             : coefficient bank write port, honoured only while idle
//
// Build option: FIR_SAT_EN clamps the result to the DATA_W range instead of wrapping.
module fir_mac_filter
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int COEF_W = FIR_COEF_W,
    parameter int TAPS   = FIR_TAPS,
    parameter int SHIFT  = FIR_SHIFT
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic signed [DATA_W-1:0]       Xin,
    input  logic                           Xin_valid,
    output logic                           Xin_ready,
    output logic signed [DATA_W-1:0]       Yout,
    output logic                           Yout_valid,
    input  logic                           Coef_we,
    input  logic [fir_clog2(TAPS)-1:0]     Coef_addr,
    input  logic signed [COEF_W-1:0]       Coef_data
);

    localparam int AW    = fir_clog2(TAPS);
    localparam int ACC_W = DATA_W + COEF_W + AW;

    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    // 2**(SHIFT-1), or 0 when SHIFT is 0
    localparam logic signed [ACC_W:0] RND     = ((ACC_W+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] SAT_MAX = ((ACC_W+1)'(1) << (DATA_W - 1)) - (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - (ACC_W+1)'(1);

    fir_state_t state, state_nxt;

    logic signed [DATA_W-1:0] dline [TAPS];
    logic signed [COEF_W-1:0] coef  [TAPS];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            k;

    logic                     accept;
    logic                     mac_clr;
    logic                     mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    acc_rnd;
    logic signed [ACC_W:0]    shifted;
    logic signed [DATA_W-1:0] y_next;

    assign Xin_ready = (state == ST_IDLE);
    assign accept    = Xin_ready && Xin_valid;

    fir_mac #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk (Clk),
        .rst (Rst),
        .clr (mac_clr),
        .en  (mac_en),
        .a   (dline[rd_ptr]),
        .b   (coef[k]),
        .acc (acc)
    );

    always_comb begin
        state_nxt = state;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Xin_valid) begin
                    state_nxt = ST_MAC;
                    mac_clr   = 1'b1;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (k == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Extra headroom bit so adding the rounding constant cannot wrap.
    assign acc_rnd = {acc[ACC_W-1], acc} + RND;
    assign shifted = acc_rnd >>> SHIFT;

`ifdef FIR_SAT_EN
    always_comb begin
        if (shifted > SAT_MAX) begin
            y_next = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            y_next = SAT_MIN[DATA_W-1:0];
        end else begin
            y_next = shifted[DATA_W-1:0];
        end
    end
`else
    logic unused_shifted_msbs;
    assign unused_shifted_msbs = ^{shifted[ACC_W:DATA_W], SAT_MAX, SAT_MIN};
    assign y_next = shifted[DATA_W-1:0];
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            k          <= '0;
            Yout       <= '0;
            Yout_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            Yout_valid <= 1'b0;

            // Written on the accept edge too, so the new value is seen by that sample's MAC pass.
            if (Xin_ready && Coef_we && (int'(Coef_addr) < TAPS)) begin
                coef[Coef_addr] <= Coef_data;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dline[wr_ptr] <= Xin;
                        wr_ptr        <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                        // newest sample lives at the slot just written; walk backwards from it
                        rd_ptr        <= wr_ptr;
                        k             <= '0;
                    end
                end
                ST_MAC: begin
                    k      <= k + 1'b1;
                    rd_ptr <= (rd_ptr == '0) ? LAST_IDX : rd_ptr - 1'b1;
                end
                ST_DONE: begin
                    Yout       <= y_next;
                    Yout_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb/tb_fir_mac_filter.sv - scoreboard bench for fir_mac_filter with default parameters
module tb_fir_mac_filter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [15:0] Xin = '0;
    logic        Xin_valid = 1'b0;
    logic        Xin_ready;
    logic [15:0] Yout;
    logic        Yout_valid;
    logic        Coef_we = 1'b0;
    logic [3:0]  Coef_addr = '0;
    logic [15:0] Coef_data = '0;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    always #5 Clk = ~Clk;

    fir_mac_filter dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Xin        (Xin),
        .Xin_valid  (Xin_valid),
        .Xin_ready  (Xin_ready),
        .Yout       (Yout),
        .Yout_valid (Yout_valid),
        .Coef_we    (Coef_we),
        .Coef_addr  (Coef_addr),
        .Coef_data  (Coef_data)
    );

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        Rst = 1'b1;
        Xin_valid = 1'b0;
        Coef_we = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic wr_coef(input int a, input logic [15:0] d);
        Coef_we = 1'b1;
        Coef_addr = a[3:0];
        Coef_data = d;
        @(negedge Clk);
        Coef_we = 1'b0;
    endtask

    task automatic send(input logic [15:0] x);
        int t;
        t = 0;
        while (!Xin_ready && t < 40) begin
            @(negedge Clk);
            t++;
        end
        if (!Xin_ready) begin
            $display("FAIL send_ready_timeout got=%b want=1", Xin_ready);
            n_err++;
            n_vec++;
        end
        Xin = x;
        Xin_valid = 1'b1;
        @(negedge Clk);
        Xin_valid = 1'b0;
    endtask

    task automatic wait_out(output bit got);
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (Yout_valid) got = 1'b1;
            else @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (Xin_ready !== 1'b1) begin
            $display("FAIL reset_ready got=%b want=1", Xin_ready); n_err++;
        end
        n_vec++;
        if (Yout !== 16'h0000) begin
            $display("FAIL reset_yout got=%h want=0000", Yout); n_err++;
        end
        n_vec++;
        if (Yout_valid !== 1'b0) begin
            $display("FAIL reset_yvalid got=%b want=0", Yout_valid); n_err++;
        end
    endtask

    task automatic test_impulse();
        int ie[6] = '{8192, 4096, 2048, 1024, 0, 0};
        bit got;
        logic [15:0] e;
        do_reset();
        wr_coef(0, 16'h4000);
        wr_coef(1, 16'h2000);
        wr_coef(2, 16'h1000);
        wr_coef(3, 16'h0800);
        for (int i = 4; i < 16; i++) wr_coef(i, 16'h0000);
        for (int i = 0; i < 6; i++) begin
            send((i == 0) ? 16'h4000 : 16'h0000);
            exp_q.push_back(ie[i][15:0]);
            wait_out(got);
            n_vec++;
            if (!got) begin
                $display("FAIL impulse_timeout idx=%0d got=no_pulse want=pulse", i); n_err++;
                exp_q.delete();
            end else begin
                e = exp_q.pop_front();
                if (Yout !== e) begin
                    $display("FAIL impulse idx=%0d got=%0d want=%0d", i, $signed(Yout), $signed(e)); n_err++;
                end
            end
        end
    endtask

    task automatic test_negative();
        bit got;
        logic [15:0] e;
        do_reset();
        wr_coef(0, 16'h4000);
        send(16'h8000);
        exp_q.push_back(16'hC000);
        wait_out(got);
        n_vec++;
        if (!got) begin
            $display("FAIL negative_timeout got=no_pulse want=pulse"); n_err++;
        end else begin
            e = exp_q.pop_front();
            if (Yout !== e) begin
                $display("FAIL negative got=%h want=%h", Yout, e); n_err++;
            end
        end
    endtask

    task automatic test_overflow();
        bit got;
        logic [15:0] e;
        do_reset();
        for (int i = 0; i < 16; i++) wr_coef(i, 16'h7FFF);
        exp_q.push_back(16'd32766);
`ifdef FIR_SAT_EN
        exp_q.push_back(16'h7FFF);
`else
        exp_q.push_back(16'hFFFC);
`endif
        for (int i = 0; i < 2; i++) begin
            send(16'h7FFF);
            wait_out(got);
            n_vec++;
            if (!got) begin
                $display("FAIL overflow_timeout idx=%0d got=no_pulse want=pulse", i); n_err++;
            end else begin
                e = exp_q.pop_front();
                if (Yout !== e) begin
                    $display("FAIL overflow idx=%0d got=%h want=%h", i, Yout, e); n_err++;
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_handshake();
        int acc_e[$];
        int val_e[$];
        bit prev_v;
        int dbl;
        bit got;
        logic [15:0] e;
        do_reset();
        prev_v = 1'b0;
        dbl = 0;
        Xin = 16'h0000;
        Xin_valid = 1'b1;
        // negedge i sits between posedge i and i+1: accepts land on edge i+1,
        // a pulse seen here was registered on edge i
        for (int i = 0; i < 100; i++) begin
            if (Xin_ready) begin
                acc_e.push_back(i + 1);
                exp_q.push_back(16'h0000);
            end
            if (Yout_valid) begin
                val_e.push_back(i);
                if (prev_v) dbl++;
                n_vec++;
                e = exp_q.pop_front();
                if (Yout !== e) begin
                    $display("FAIL hs_yout cyc=%0d got=%h want=%h", i, Yout, e); n_err++;
                end
            end
            prev_v = Yout_valid;
            @(negedge Clk);
        end
        Xin_valid = 1'b0;
        n_vec++;
        if (acc_e.size() != 6) begin
            $display("FAIL hs_accept_count got=%0d want=6", acc_e.size()); n_err++;
        end
        n_vec++;
        if (val_e.size() != 5) begin
            $display("FAIL hs_pulse_count got=%0d want=5", val_e.size()); n_err++;
        end
        for (int i = 1; i < acc_e.size(); i++) begin
            n_vec++;
            if (acc_e[i] - acc_e[i-1] != 18) begin
                $display("FAIL hs_accept_interval idx=%0d got=%0d want=18", i, acc_e[i] - acc_e[i-1]); n_err++;
            end
        end
        for (int i = 0; i < val_e.size() && i < acc_e.size(); i++) begin
            n_vec++;
            if (val_e[i] - acc_e[i] != 17) begin
                $display("FAIL hs_latency idx=%0d got=%0d want=17", i, val_e[i] - acc_e[i]); n_err++;
            end
        end
        n_vec++;
        if (dbl != 0) begin
            $display("FAIL hs_pulse_width got=%0d_long_pulses want=0", dbl); n_err++;
        end
        wait_out(got);
        n_vec++;
        if (!got || exp_q.size() == 0) begin
            $display("FAIL hs_drain got=%b want=1", got); n_err++;
        end else begin
            e = exp_q.pop_front();
            if (Yout !== e) begin
                $display("FAIL hs_drain_yout got=%h want=%h", Yout, e); n_err++;
            end
        end
        @(negedge Clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            $display("FAIL hs_queue_left got=%0d want=0", exp_q.size()); n_err++;
        end
        exp_q.delete();
    endtask

    task automatic test_coef_gating();
        bit got;
        logic [15:0] e;
        do_reset();
        wr_coef(0, 16'h4000);
        send(16'h4000);
        exp_q.push_back(16'd8192);
        repeat (3) @(negedge Clk);
        n_vec++;
        if (Xin_ready !== 1'b0) begin
            $display("FAIL gate_busy_ready got=%b want=0", Xin_ready); n_err++;
        end
        Coef_we = 1'b1; Coef_addr = 4'd0; Coef_data = 16'h1000;
        @(negedge Clk);
        Coef_we = 1'b0;
        wait_out(got);
        n_vec++;
        if (!got) begin
            $display("FAIL gate_first_timeout got=no_pulse want=pulse"); n_err++;
        end else begin
            e = exp_q.pop_front();
            if (Yout !== e) begin
                $display("FAIL gate_first got=%0d want=%0d", Yout, e); n_err++;
            end
        end
        send(16'h4000);
        exp_q.push_back(16'd8192);
        wait_out(got);
        n_vec++;
        if (!got) begin
            $display("FAIL gate_dropped_timeout got=no_pulse want=pulse"); n_err++;
        end else begin
            e = exp_q.pop_front();
            if (Yout !== e) begin
                $display("FAIL gate_dropped_write got=%0d want=%0d", Yout, e); n_err++;
            end
        end
        Coef_we = 1'b1; Coef_addr = 4'd0; Coef_data = 16'h2000;
        Xin = 16'h4000; Xin_valid = 1'b1;
        exp_q.push_back(16'd4096);
        @(negedge Clk);
        Coef_we = 1'b0; Xin_valid = 1'b0;
        wait_out(got);
        n_vec++;
        if (!got) begin
            $display("FAIL gate_same_edge_timeout got=no_pulse want=pulse"); n_err++;
        end else begin
            e = exp_q.pop_front();
            if (Yout !== e) begin
                $display("FAIL gate_same_edge got=%0d want=%0d", Yout, e); n_err++;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_mid_reset();
        bit got;
        int pulses;
        logic [15:0] e;
        do_reset();
        wr_coef(0, 16'h4000);
        send(16'h4000);
        repeat (5) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        n_vec++;
        if (Xin_ready !== 1'b1) begin
            $display("FAIL midrst_ready got=%b want=1", Xin_ready); n_err++;
        end
        n_vec++;
        if (Yout !== 16'h0000) begin
            $display("FAIL midrst_yout got=%h want=0000", Yout); n_err++;
        end
        n_vec++;
        if (Yout_valid !== 1'b0) begin
            $display("FAIL midrst_yvalid got=%b want=0", Yout_valid); n_err++;
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (Yout_valid) pulses++;
            @(negedge Clk);
        end
        n_vec++;
        if (pulses != 0) begin
            $display("FAIL midrst_aborted_pulse got=%0d want=0", pulses); n_err++;
        end
        send(16'h4000);
        exp_q.push_back(16'h0000);
        wait_out(got);
        n_vec++;
        if (!got) begin
            $display("FAIL midrst_next_timeout got=no_pulse want=pulse"); n_err++;
        end else begin
            e = exp_q.pop_front();
            if (Yout !== e) begin
                $display("FAIL midrst_next got=%h want=%h", Yout, e); n_err++;
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_negative();
        test_overflow();
        test_handshake();
        test_coef_gating();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
